// File: rtl/muldiv_unit_pkg.sv
// Shared types and decode helpers for the iterative RV64M multiply/divide unit.
package muldiv_unit_pkg;

  typedef enum logic [3:0] {
    MdMul    = 4'd0,
    MdMulh   = 4'd1,
    MdMulhsu = 4'd2,
    MdMulhu  = 4'd3,
    MdMulw   = 4'd4,
    MdDiv    = 4'd5,
    MdDivu   = 4'd6,
    MdRem    = 4'd7,
    MdRemu   = 4'd8,
    MdDivw   = 4'd9,
    MdDivuw  = 4'd10,
    MdRemw   = 4'd11,
    MdRemuw  = 4'd12
  } mdfunc_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } md_state_e;

  localparam int unsigned MD_ITER_64 = 64;
  localparam int unsigned MD_ITER_32 = 32;

  function automatic logic is_div(mdfunc_t f);
    return f inside {MdDiv, MdDivu, MdRem, MdRemu, MdDivw, MdDivuw, MdRemw, MdRemuw};
  endfunction

  function automatic logic is_rem(mdfunc_t f);
    return f inside {MdRem, MdRemu, MdRemw, MdRemuw};
  endfunction

  function automatic logic is_w(mdfunc_t f);
    return f inside {MdMulw, MdDivw, MdDivuw, MdRemw, MdRemuw};
  endfunction

  // rs1 treated as signed; MUL/MULW are excluded since their low bits are sign-agnostic.
  function automatic logic is_signed(mdfunc_t f);
    return f inside {MdMulh, MdMulhsu, MdDiv, MdRem, MdDivw, MdRemw};
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module muldiv_unit_div_iter #(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] divisor,
  input  logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    // Borrow out of the top bit means the divisor did not fit: restore.
    if (diff[XLEN]) begin
      rem_next = shifted[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end else begin
      rem_next = diff[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV64M multiply/divide unit: shift-add multiply and restoring divide on
// magnitudes, one bit per cycle, with sign fix-up and W-op extension at the end.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ITER_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  mdfunc_t         mdfunc,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int unsigned WLEN = 32;

  function automatic logic [XLEN-1:0] sext_w(logic [WLEN-1:0] v);
    return {{(XLEN-WLEN){v[WLEN-1]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext_w(logic [WLEN-1:0] v);
    return {{(XLEN-WLEN){1'b0}}, v};
  endfunction

  md_state_e         state_q;
  mdfunc_t           func_q;
  logic [ITER_W-1:0] cnt_q;
  // Multiply: acc = product, mcand = shifted multiplicand, mplier = remaining multiplier.
  // Divide:   acc[XLEN-1:0] = partial remainder, mcand[XLEN-1:0] = divisor, mplier = quotient.
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic              neg_res_q;
  logic              neg_rem_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [XLEN-1:0]   result_q;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

  // Operand preparation for the op being offered.
  logic            op_w, op_s1, op_s2, op_div, op_rem;
  logic [XLEN-1:0] op_a, op_b, a_ext, mag_a, mag_b, min_neg, spec_res;
  logic            neg_a, neg_b, div_zero, div_ovf;

  always_comb begin
    op_w   = is_w(mdfunc);
    op_s1  = is_signed(mdfunc);
    op_s2  = op_s1 && (mdfunc != MdMulhsu);
    op_div = is_div(mdfunc);
    op_rem = is_rem(mdfunc);
    a_ext  = op_w ? sext_w(src1[WLEN-1:0]) : src1;
    if (op_w) begin
      op_a = op_s1 ? sext_w(src1[WLEN-1:0]) : zext_w(src1[WLEN-1:0]);
      op_b = op_s2 ? sext_w(src2[WLEN-1:0]) : zext_w(src2[WLEN-1:0]);
    end else begin
      op_a = src1;
      op_b = src2;
    end
    neg_a    = op_s1 & op_a[XLEN-1];
    neg_b    = op_s2 & op_b[XLEN-1];
    mag_a    = neg_a ? -op_a : op_a;
    mag_b    = neg_b ? -op_b : op_b;
    min_neg  = op_w ? sext_w({1'b1, {(WLEN-1){1'b0}}}) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = op_div && (op_b == '0);
    div_ovf  = op_div && op_s1 && (op_a == min_neg) && (op_b == '1);
    if (op_rem) begin
      spec_res = div_zero ? a_ext : '0;
    end else begin
      spec_res = div_zero ? '1 : a_ext;
    end
  end

  // One iteration of each datapath.
  logic [2*XLEN-1:0] acc_step;
  logic [XLEN-1:0]   div_rem_step;
  logic [XLEN-1:0]   div_quo_step;

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  muldiv_unit_div_iter #(
    .XLEN(XLEN)
  ) u_div_iter (
    .rem      (acc_q[XLEN-1:0]),
    .divisor  (mcand_q[XLEN-1:0]),
    .quo      (mplier_q),
    .rem_next (div_rem_step),
    .quo_next (div_quo_step)
  );

  // Final result built from the last iteration's outputs.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo_fix, rem_fix, div_sel, final_res;

  always_comb begin
    prod    = neg_res_q ? -acc_step : acc_step;
    quo_fix = neg_res_q ? -div_quo_step : div_quo_step;
    rem_fix = neg_rem_q ? -div_rem_step : div_rem_step;
    div_sel = is_rem(func_q) ? rem_fix : quo_fix;
    if (is_div(func_q)) begin
      final_res = is_w(func_q) ? sext_w(div_sel[WLEN-1:0]) : div_sel;
    end else if (func_q == MdMul) begin
      final_res = prod[XLEN-1:0];
    end else if (func_q == MdMulw) begin
      final_res = sext_w(prod[WLEN-1:0]);
    end else begin
      final_res = prod[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      func_q      <= MdMul;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else if (flush) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            func_q     <= mdfunc;
            neg_res_q  <= neg_a ^ neg_b;
            neg_rem_q  <= neg_a;
            acc_q      <= '0;
            mcand_q    <= {{XLEN{1'b0}}, (op_div ? mag_b : mag_a)};
            // W dividends start in the top half so the MSB-first walk sees them.
            mplier_q   <= !op_div ? mag_b : (op_w ? (mag_a << WLEN) : mag_a);
            in_ready_q <= 1'b0;
            if (div_zero || div_ovf) begin
              state_q     <= StDone;
              out_valid_q <= 1'b1;
              result_q    <= spec_res;
            end else begin
              state_q <= StBusy;
              cnt_q   <= op_w ? ITER_W'(MD_ITER_32 - 1) : ITER_W'(MD_ITER_64 - 1);
            end
          end
        end
        StBusy: begin
          if (is_div(func_q)) begin
            acc_q    <= {{XLEN{1'b0}}, div_rem_step};
            mplier_q <= div_quo_step;
          end else begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
          end
          if (cnt_q == '0) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
            result_q    <= final_res;
          end else begin
            cnt_q <= cnt_q - ITER_W'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with an arithmetic reference model and a per-cycle checker.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  mdfunc_t     mdfunc;
  logic [63:0] src1, src2, result;

  int          checks = 0;
  int          fails  = 0;
  logic        pending;
  logic [63:0] exp_res;

  always #5 clk = ~clk;

  muldiv_unit #(
    .XLEN   (64),
    .ITER_W (7)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mdfunc    (mdfunc),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference: plain arithmetic on the architectural definitions.
  function automatic logic [63:0] model(input mdfunc_t f, input logic [63:0] a,
                                        input logic [63:0] b);
    logic [127:0]       p;
    logic signed [63:0] sa, sb, sq;
    logic signed [31:0] sa32, sb32, sq32;
    logic [31:0]        u32;
    logic               ovf64, ovf32;
    sa    = a;
    sb    = b;
    sa32  = a[31:0];
    sb32  = b[31:0];
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    ovf32 = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    case (f)
      MdMul:    return a * b;
      MdMulh:   begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      MdMulhsu: begin p = {{64{a[63]}}, a} * {64'd0, b};       return p[127:64]; end
      MdMulhu:  begin p = {64'd0, a} * {64'd0, b};             return p[127:64]; end
      MdMulw:   begin u32 = a[31:0] * b[31:0]; return sx32(u32); end
      MdDiv: begin
        if (b == 0) return '1;
        if (ovf64) return a;
        sq = sa / sb; return sq;
      end
      MdRem: begin
        if (b == 0) return a;
        if (ovf64) return '0;
        sq = sa % sb; return sq;
      end
      MdDivu:   return (b == 0) ? '1 : a / b;
      MdRemu:   return (b == 0) ? a : a % b;
      MdDivw: begin
        if (b[31:0] == 0) return '1;
        if (ovf32) return sx32(a[31:0]);
        sq32 = sa32 / sb32; return sx32(sq32);
      end
      MdRemw: begin
        if (b[31:0] == 0) return sx32(a[31:0]);
        if (ovf32) return '0;
        sq32 = sa32 % sb32; return sx32(sq32);
      end
      MdDivuw: begin
        if (b[31:0] == 0) return '1;
        u32 = a[31:0] / b[31:0]; return sx32(u32);
      end
      MdRemuw: begin
        if (b[31:0] == 0) return sx32(a[31:0]);
        u32 = a[31:0] % b[31:0]; return sx32(u32);
      end
      default: return '0;
    endcase
  endfunction

  // Every cycle with a result on offer: it must be expected, match the model, and block issue.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      check("out_valid_expected", {63'd0, pending}, 64'd1);
      check("result_vs_model", result, exp_res);
      check("in_ready_low_while_done", {63'd0, in_ready}, 64'd0);
    end
  end

  task automatic offer(input mdfunc_t f, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    mdfunc   = f;
    src1     = a;
    src2     = b;
    in_valid = 1'b1;
    exp_res  = model(f, a, b);
    pending  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input mdfunc_t f, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_lit, input int exp_lat,
                        input int hold);
    int lat;
    check({name, "_model"}, model(f, a, b), exp_lit);
    offer(f, a, b);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_result"}, result, exp_lit);
    repeat (hold) @(negedge clk);
    if (hold > 0) begin
      check({name, "_held_valid"}, {63'd0, out_valid}, 64'd1);
      check({name, "_held_result"}, result, exp_lit);
    end
    out_ready = 1'b1;
    @(posedge clk);
    pending = 1'b0;
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({name, "_valid_dropped"}, {63'd0, out_valid}, 64'd0);
    check({name, "_ready_back"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mdfunc = MdMul; src1 = '0; src2 = '0; pending = 1'b0; exp_res = '0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_result", result, 64'd0);
    reset = 1'b0;

    run_op("mul_7_m3", MdMul, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
    run_op("mulhu_ones", MdMulhu, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
    run_op("mulh_m1_m1", MdMulh, '1, '1, 64'd0, 65, 0);
    run_op("mulhsu_m1_2", MdMulhsu, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("div_m7_2", MdDiv, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    run_op("rem_m7_2", MdRem, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("divu_by0", MdDivu, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op("remu_by0", MdRemu, 64'd100, 64'd0, 64'd100, 1, 0);
    run_op("div_ovf", MdDiv, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0);
    run_op("rem_ovf", MdRem, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0);
    run_op("divw_ovf", MdDivw, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1, 0);
    run_op("remw_m7_2", MdRemw, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
    run_op("divuw_hold", MdDivuw, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33, 10);

    // Flush in BUSY cycle 20 of a DIV: nothing may come out.
    offer(MdDiv, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    repeat (19) @(negedge clk);
    flush   = 1'b1;
    pending = 1'b0;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy_in_ready", {63'd0, in_ready}, 64'd1);
    check("flush_busy_out_valid", {63'd0, out_valid}, 64'd0);
    repeat (70) @(negedge clk);
    check("flush_busy_no_result", {63'd0, out_valid}, 64'd0);

    run_op("mulw_after_flush", MdMulw, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0);

    // Flush on the same edge as an accept drops the op.
    @(negedge clk);
    mdfunc = MdMul; src1 = 64'd3; src2 = 64'd5; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("flush_accept_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (70) @(negedge clk);
    check("flush_accept_no_result", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset in the middle of BUSY.
    offer(MdMul, 64'd11, 64'd13);
    repeat (10) @(negedge clk);
    pending = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midreset_in_ready", {63'd0, in_ready}, 64'd1);
    check("midreset_out_valid", {63'd0, out_valid}, 64'd0);
    check("midreset_result", result, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (70) @(negedge clk);
    check("midreset_no_result", {63'd0, out_valid}, 64'd0);

    run_op("divu_100_7", MdDivu, 64'd100, 64'd7, 64'd14, 65, 0);
    run_op("remu_100_7", MdRemu, 64'd100, 64'd7, 64'd2, 65, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
